// File: rtl/palette_pkg.sv
// Shared defaults, colour type and power-on palette for the palette lookup block.
package palette_pkg;

    localparam int DEF_IDX_W      = 5;
    localparam int DEF_RGB_W      = 24;
    localparam int DEF_CYC_PERIOD = 4;
    localparam int DEFAULT_DEPTH  = 2 ** DEF_IDX_W;

    typedef logic [DEF_RGB_W-1:0] rgb_t;

    localparam rgb_t DEFAULT_PALETTE [DEFAULT_DEPTH] = '{
        0:       24'h800080,
        8:       24'hf81d12,
        16:      24'h996633,
        default: 24'h000000
    };

    // Tables deeper than the default palette fill their extra entries with black.
    function automatic rgb_t default_entry(input int unsigned i);
        if (i < DEFAULT_DEPTH) begin
            return DEFAULT_PALETTE[i[DEF_IDX_W-1:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/palette_cycler.sv
// Colour-cycle offset counter and read-index remap; only built with PALETTE_CYCLE_EN.
module palette_cycler
    import palette_pkg::*;
#(
    parameter int IDX_W      = DEF_IDX_W,
    parameter int CYC_PERIOD = DEF_CYC_PERIOD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] cyc_lo,
    input  logic [IDX_W-1:0] cyc_hi,
    input  logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] remap_idx
);

    localparam int FRAME_W = (CYC_PERIOD > 1) ? $clog2(CYC_PERIOD) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(CYC_PERIOD - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     len;
    logic [IDX_W:0]     off_inc;
    logic [IDX_W:0]     sum;
    logic               range_ok;
    logic               in_range;
    logic               step;

    // len is one bit wider so a full-table range (len = 2**IDX_W) is representable.
    always_comb begin
        range_ok  = (cyc_hi >= cyc_lo);
        len       = {1'b0, cyc_hi} - {1'b0, cyc_lo} + (IDX_W+1)'(1);
        step      = frame_start && (frame_cnt == FRAME_LAST);
        off_inc   = {1'b0, off} + (IDX_W+1)'(1);
        sum       = {1'b0, index - cyc_lo} + {1'b0, off};
        if (sum >= len) begin
            sum = sum - len;
        end
        in_range  = range_ok && (index >= cyc_lo) && (index <= cyc_hi);
        remap_idx = in_range ? (cyc_lo + sum[IDX_W-1:0]) : index;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            off       <= '0;
        end else begin
            if (frame_start) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FRAME_W'(1);
            end
            // A shrunk or inverted range clears a stale offset before it can be stepped.
            if (!range_ok || ({1'b0, off} >= len)) begin
                off <= '0;
            end else if (step) begin
                off <= (off_inc == len) ? '0 : off_inc[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/palette_ram.sv
// Registered palette lookup with colour key; colour cycling enabled by PALETTE_CYCLE_EN.
module palette_ram
    import palette_pkg::*;
#(
    parameter int IDX_W           = DEF_IDX_W,
    parameter int RGB_W           = DEF_RGB_W,
    parameter int TRANSPARENT_IDX = 0,
    parameter int CYC_PERIOD      = DEF_CYC_PERIOD
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] index,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [RGB_W-1:0] wr_data,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] cyc_lo,
    input  logic [IDX_W-1:0] cyc_hi,
    output logic [RGB_W-1:0] RGB,
    output logic             RGB_valid,
    output logic             transparent
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] KEY_IDX = IDX_W'(TRANSPARENT_IDX);

    logic [RGB_W-1:0] pal_mem [DEPTH];
    logic [IDX_W-1:0] eff_idx;

`ifdef PALETTE_CYCLE_EN
    palette_cycler #(
        .IDX_W      (IDX_W),
        .CYC_PERIOD (CYC_PERIOD)
    ) u_cycler (
        .clk         (Clk),
        .reset_n     (Reset_n),
        .frame_start (frame_start),
        .cyc_lo      (cyc_lo),
        .cyc_hi      (cyc_hi),
        .index       (index),
        .remap_idx   (eff_idx)
    );
`else
    logic unused_cycle_inputs;
    assign unused_cycle_inputs = ^{frame_start, cyc_lo, cyc_hi};
    assign eff_idx = index;
`endif

    // Reset reloads the palette and drops any write or lookup on the same edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal_mem[i] <= RGB_W'(default_entry(i));
            end
            RGB         <= '0;
            RGB_valid   <= 1'b0;
            transparent <= 1'b0;
        end else begin
            if (wr_en) begin
                pal_mem[wr_addr] <= wr_data;
            end
            if (pix_valid) begin
                RGB         <= (wr_en && (wr_addr == eff_idx)) ? wr_data : pal_mem[eff_idx];
                RGB_valid   <= 1'b1;
                transparent <= (index == KEY_IDX);
            end else begin
                RGB_valid   <= 1'b0;
                transparent <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_palette_ram.sv
// Directed vector bench for palette_ram; cycling checks compile only with PALETTE_CYCLE_EN.
module tb_palette_ram;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [4:0]  index;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic        frame_start;
    logic [4:0]  cyc_lo;
    logic [4:0]  cyc_hi;
    logic [23:0] RGB;
    logic        RGB_valid;
    logic        transparent;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        pv;
        logic [4:0]  idx;
        logic        we;
        logic [4:0]  wa;
        logic [23:0] wd;
        logic [23:0] e_rgb;
        logic        e_v;
        logic        e_t;
    } vec_t;

    vec_t vecs [14];

    palette_ram #(
        .IDX_W           (5),
        .RGB_W           (24),
        .TRANSPARENT_IDX (0),
        .CYC_PERIOD      (4)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_valid   (pix_valid),
        .index       (index),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .cyc_lo      (cyc_lo),
        .cyc_hi      (cyc_hi),
        .RGB         (RGB),
        .RGB_valid   (RGB_valid),
        .transparent (transparent)
    );

    always #5 Clk = ~Clk;

    // Drives one cycle of inputs, then samples 1 time unit after the edge.
    task automatic applyStimulus(input logic pv, input logic [4:0] idx, input logic we,
                                 input logic [4:0] wa, input logic [23:0] wd);
        pix_valid = pv;
        index     = idx;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        @(posedge Clk);
        #1;
        pix_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [23:0] e_rgb,
                               input logic e_v, input logic e_t);
        n_vec++;
        if (RGB !== e_rgb || RGB_valid !== e_v || transparent !== e_t) begin
            n_fail++;
            $display("[TB] FAIL %s: got RGB=%h valid=%b transparent=%b, expected RGB=%h valid=%b transparent=%b",
                     name, RGB, RGB_valid, transparent, e_rgb, e_v, e_t);
        end
    endtask

    task automatic readCheck(input string name, input logic [4:0] idx, input logic [23:0] e_rgb);
        applyStimulus(1'b1, idx, 1'b0, 5'd0, 24'h0);
        checkOutput(name, e_rgb, 1'b1, idx == 5'd0);
    endtask

    task automatic resetDut();
        Reset_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 24'h0);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 24'h0);
        Reset_n = 1'b1;
    endtask

    task automatic pulseFrames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b1;
            applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 24'h0);
            frame_start = 1'b0;
            applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 24'h0);
        end
    endtask

    initial begin
        Reset_n     = 1'b0;
        pix_valid   = 1'b0;
        index       = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        frame_start = 1'b0;
        cyc_lo      = 5'd9;
        cyc_hi      = 5'd2;

        vecs[0]  = '{1'b1, 5'd8,  1'b0, 5'd0, 24'h000000, 24'hf81d12, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  1'b0, 5'd0, 24'h000000, 24'h800080, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 5'd0,  1'b0, 5'd0, 24'h000000, 24'h800080, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd16, 1'b0, 5'd0, 24'h000000, 24'h996633, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 5'd3,  1'b0, 5'd0, 24'h000000, 24'h000000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd5,  1'b1, 5'd5, 24'h123456, 24'h123456, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd5,  1'b0, 5'd0, 24'h000000, 24'h123456, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd5,  1'b1, 5'd9, 24'habcdef, 24'h123456, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd9,  1'b0, 5'd0, 24'h000000, 24'habcdef, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 5'd8,  1'b1, 5'd9, 24'h111111, 24'hf81d12, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd9,  1'b0, 5'd0, 24'h000000, 24'h111111, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 5'd31, 1'b0, 5'd0, 24'h000000, 24'h000000, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 5'd0,  1'b1, 5'd0, 24'h0000ff, 24'h0000ff, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 5'd0,  1'b0, 5'd0, 24'h000000, 24'h0000ff, 1'b0, 1'b0};

        resetDut();
        checkOutput("reset_outputs", 24'h0, 1'b0, 1'b0);

        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].pv, vecs[v].idx, vecs[v].we, vecs[v].wa, vecs[v].wd);
            checkOutput($sformatf("vec%0d", v), vecs[v].e_rgb, vecs[v].e_v, vecs[v].e_t);
        end

        // Reset must discard a concurrent write and drop an in-flight lookup.
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 24'h555555);
        readCheck("write_idx3", 5'd3, 24'h555555);
        Reset_n = 1'b0;
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd3, 24'h777777);
        checkOutput("reset_cycle_outputs", 24'h0, 1'b0, 1'b0);
        Reset_n = 1'b1;
        readCheck("idx3_after_reset", 5'd3, 24'h000000);
        readCheck("idx5_after_reset", 5'd5, 24'h000000);
        readCheck("idx0_after_reset", 5'd0, 24'h800080);

`ifdef PALETTE_CYCLE_EN
        resetDut();
        for (int a = 4; a < 8; a++) begin
            applyStimulus(1'b0, 5'd0, 1'b1, 5'(a), 24'h400000 + 24'(a));
        end
        cyc_lo = 5'd4;
        cyc_hi = 5'd7;
        pulseFrames(4);
        readCheck("cyc4_idx7", 5'd7, 24'h400004);
        readCheck("cyc4_idx4", 5'd4, 24'h400005);
        readCheck("cyc4_idx8", 5'd8, 24'hf81d12);
        pulseFrames(12);
        readCheck("cyc16_idx7", 5'd7, 24'h400007);
        cyc_lo = 5'd9;
        cyc_hi = 5'd2;
        pulseFrames(8);
        readCheck("inv_idx4", 5'd4, 24'h400004);
        readCheck("inv_idx7", 5'd7, 24'h400007);
        readCheck("inv_idx8", 5'd8, 24'hf81d12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
